// File: rtl/hwpe_cfg_slice.sv
// Register slice for the HWPE config port: 2-entry request skid FIFO, registered response, outstanding bound.
// Latency: request accepted at cycle t is presented downstream at t+1; response forwarded one cycle after arrival.
// Backpressure: s_gnt_o drops when the FIFO is full or MAX_OUTSTANDING transactions are unanswered; responses are never stalled.
module hwpe_cfg_slice #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BE_W           = DATA_WIDTH / 8,
  localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  // upstream request
  input  logic                  s_req_i,
  output logic                  s_gnt_o,
  input  logic [ADDR_WIDTH-1:0] s_add_i,
  input  logic                  s_we_n_i,
  input  logic [BE_W-1:0]       s_be_i,
  input  logic [DATA_WIDTH-1:0] s_wdata_i,
  input  logic [ID_WIDTH-1:0]   s_id_i,
  // upstream response
  output logic                  s_r_valid_o,
  output logic [DATA_WIDTH-1:0] s_r_rdata_o,
  output logic [ID_WIDTH-1:0]   s_r_id_o,
  // downstream request
  output logic                  m_req_o,
  input  logic                  m_gnt_i,
  output logic [ADDR_WIDTH-1:0] m_add_o,
  output logic                  m_we_n_o,
  output logic [BE_W-1:0]       m_be_o,
  output logic [DATA_WIDTH-1:0] m_wdata_o,
  output logic [ID_WIDTH-1:0]   m_id_o,
  // downstream response
  input  logic                  m_r_valid_i,
  input  logic [DATA_WIDTH-1:0] m_r_rdata_i,
  input  logic [ID_WIDTH-1:0]   m_r_id_i,
  // status
  output logic                  busy_o,
  output logic                  err_o
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  we_n;
    logic [BE_W-1:0]       be;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ID_WIDTH-1:0]   id;
  } req_t;

  req_t                  r_mem [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_cnt;
  logic [OW-1:0]         r_outst;
  logic                  r_rvalid;
  logic                  r_rspur;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ID_WIDTH-1:0]   r_rid;
  logic                  r_err;

  req_t w_in;
  req_t w_head;
  logic w_gnt;
  logic w_push;
  logic w_pop;
  logic w_spur;
  logic w_dec;

  // Grant depends on registered state only, so a same-cycle pop never opens a full FIFO.
  assign w_gnt  = !rst && (r_cnt < 2'd2) && (r_outst < OW'(MAX_OUTSTANDING));
  assign w_push = s_req_i && w_gnt;
  assign w_pop  = (r_cnt != 2'd0) && m_gnt_i;
  assign w_in   = '{add: s_add_i, we_n: s_we_n_i, be: s_be_i, wdata: s_wdata_i, id: s_id_i};
  assign w_head = r_mem[r_rptr];

  // A response with nothing unanswered and nothing already in the register is unexpected.
  assign w_spur = m_r_valid_i && (r_outst == '0) && !r_rvalid;
  // Only a legitimate forwarded response retires a transaction; the count saturates at zero.
  assign w_dec  = r_rvalid && !r_rspur && (r_outst != '0);

  // FIFO storage: payload only written on an accepted request, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_in;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 2'd1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 2'd1;
    end
  end

  // Outstanding transaction counter: +1 on accept, -1 on forwarded response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outst <= '0;
    end else if (w_push && !w_dec) begin
      r_outst <= r_outst + OW'(1);
    end else if (!w_push && w_dec) begin
      r_outst <= r_outst - OW'(1);
    end
  end

  // Response register: one-cycle valid pulse, data/id held between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rspur  <= 1'b0;
      r_rdata  <= '0;
      r_rid    <= '0;
    end else begin
      r_rvalid <= m_r_valid_i;
      r_rspur  <= w_spur;
      if (m_r_valid_i) begin
        r_rdata <= m_r_rdata_i;
        r_rid   <= m_r_id_i;
      end
    end
  end

  // Sticky error flag for unexpected responses.
  always_ff @(posedge clk) begin
    if (rst)         r_err <= 1'b0;
    else if (w_spur) r_err <= 1'b1;
  end

  assign s_gnt_o     = w_gnt;
  assign m_req_o     = (r_cnt != 2'd0);
  assign m_add_o     = w_head.add;
  assign m_we_n_o    = w_head.we_n;
  assign m_be_o      = w_head.be;
  assign m_wdata_o   = w_head.wdata;
  assign m_id_o      = w_head.id;
  assign s_r_valid_o = r_rvalid;
  assign s_r_rdata_o = r_rdata;
  assign s_r_id_o    = r_rid;
  assign busy_o      = (r_outst != '0) || (r_cnt != 2'd0);
  assign err_o       = r_err;

endmodule
